// File: rtl/ascii_result_tx.sv
// ascii_result_tx: sends a latched three-digit BCD result as ASCII text, with leading zeros suppressed and CR LF appended, over a UART 8N1 line
module ascii_result_tx #(
    parameter int CLKS_PER_BIT = 10416
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] yc,
    input  logic [3:0] yd,
    input  logic [3:0] yu,
    output logic       tx,
    output logic       busy,
    output logic       done
);
    localparam int            BW       = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0] BAUD_MAX = BW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {IDLE, LOAD, START_BIT, DATA, STOP_BIT} state_t;

    state_t        r_state, w_state_next;
    logic [BW-1:0] r_baud, w_baud_next;
    logic [2:0]    r_bit, w_bit_next;
    logic [2:0]    r_idx, w_idx_next;
    logic [2:0]    r_len, w_len;
    logic [3:0]    r_yc, r_yd, r_yu;
    logic [7:0]    r_chars [8];
    logic [7:0]    w_chars [8];
    logic [7:0]    w_hc, w_tc, w_uc;
    logic          r_tx, r_busy, r_done;
    logic          w_tx_next, w_done_next, w_baud_end;

    function automatic logic [7:0] to_ascii(input logic [3:0] d);
        return (d <= 4'd9) ? {4'h3, d} : 8'h3F;
    endfunction

    assign tx   = r_tx;
    assign busy = r_busy;
    assign done = r_done;

    // character list from the latched digits; a raw nonzero code (including 10-15) keeps the leading digit
    always_comb begin
        w_hc = to_ascii(r_yc);
        w_tc = to_ascii(r_yd);
        w_uc = to_ascii(r_yu);
        for (int i = 0; i < 8; i++) w_chars[i] = 8'h00;
        w_len = 3'd3;
        if (r_yc != 4'd0) begin
            w_chars[0] = w_hc;
            w_chars[1] = w_tc;
            w_chars[2] = w_uc;
            w_chars[3] = 8'h0D;
            w_chars[4] = 8'h0A;
            w_len      = 3'd5;
        end else if (r_yd != 4'd0) begin
            w_chars[0] = w_tc;
            w_chars[1] = w_uc;
            w_chars[2] = 8'h0D;
            w_chars[3] = 8'h0A;
            w_len      = 3'd4;
        end else begin
            w_chars[0] = w_uc;
            w_chars[1] = 8'h0D;
            w_chars[2] = 8'h0A;
        end
    end

    // next state, counters and the value tx takes after the edge (tx is registered from the next state)
    always_comb begin
        w_state_next = r_state;
        w_baud_next  = r_baud;
        w_bit_next   = r_bit;
        w_idx_next   = r_idx;
        w_done_next  = 1'b0;
        w_baud_end   = (r_baud == BAUD_MAX);
        case (r_state)
            IDLE: begin
                if (start) w_state_next = LOAD;
            end
            LOAD: begin
                w_state_next = START_BIT;
                w_idx_next   = 3'd0;
                w_baud_next  = '0;
            end
            START_BIT: begin
                w_baud_next = w_baud_end ? '0 : r_baud + 1'b1;
                if (w_baud_end) begin
                    w_state_next = DATA;
                    w_bit_next   = 3'd0;
                end
            end
            DATA: begin
                w_baud_next = w_baud_end ? '0 : r_baud + 1'b1;
                if (w_baud_end) begin
                    if (r_bit == 3'd7) w_state_next = STOP_BIT;
                    else               w_bit_next   = r_bit + 3'd1;
                end
            end
            STOP_BIT: begin
                w_baud_next = w_baud_end ? '0 : r_baud + 1'b1;
                if (w_baud_end) begin
                    if (r_idx == r_len - 3'd1) begin
                        w_state_next = IDLE;
                        w_done_next  = 1'b1;
                    end else begin
                        w_idx_next   = r_idx + 3'd1;
                        w_state_next = START_BIT;
                    end
                end
            end
            default: w_state_next = IDLE;
        endcase
        w_tx_next = (w_state_next == START_BIT) ? 1'b0 :
                    (w_state_next == DATA)      ? r_chars[w_idx_next][w_bit_next] : 1'b1;
    end

    // state, counters and registered line outputs; reset abandons any message in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_baud  <= '0;
            r_bit   <= 3'd0;
            r_idx   <= 3'd0;
            r_tx    <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_baud  <= w_baud_next;
            r_bit   <= w_bit_next;
            r_idx   <= w_idx_next;
            r_tx    <= w_tx_next;
            r_busy  <= (w_state_next != IDLE);
            r_done  <= w_done_next;
        end
    end

    // digits are latched only on an accepted start; the character list is frozen in LOAD
    always_ff @(posedge clk) begin
        if (rst) begin
            r_yc  <= 4'd0;
            r_yd  <= 4'd0;
            r_yu  <= 4'd0;
            r_len <= 3'd0;
            for (int i = 0; i < 8; i++) r_chars[i] <= 8'h00;
        end else begin
            if (r_state == IDLE && start) begin
                r_yc <= yc;
                r_yd <= yd;
                r_yu <= yu;
            end
            if (r_state == LOAD) begin
                r_chars <= w_chars;
                r_len   <= w_len;
            end
        end
    end
endmodule

// File: tb/tb_ascii_result_tx.sv
// tb_ascii_result_tx: directed checks of the ASCII result transmitter with 4 clocks per bit
module tb_ascii_result_tx;
    localparam int CPB = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [3:0] yc = 4'd0, yd = 4'd0, yu = 4'd0;
    logic       tx, busy, done;
    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;
    int         t0, dn, e;

    ascii_result_tx #(.CLKS_PER_BIT(CPB)) dut (
        .clk(clk), .rst(rst), .start(start),
        .yc(yc), .yd(yd), .yu(yu),
        .tx(tx), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // edge counter: after posedge k, cyc == k
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic wait_to(input int t);
        while (cyc < t) begin
            @(posedge clk);
            #1;
        end
    endtask

    // pulse start in the current cycle, then check every frame at mid-bit and the done timing
    task automatic run_msg(input logic [3:0] c, input logic [3:0] d, input logic [3:0] u,
                           input int n, input logic [39:0] want, input string name);
        int         ee;
        logic [9:0] f;
        yc = c; yd = d; yu = u; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        ee = cyc;
        chk($sformatf("%s busy@E", name), {31'd0, busy}, 32'd1);
        chk($sformatf("%s tx@E", name), {31'd0, tx}, 32'd1);
        wait_to(ee + 1);
        chk($sformatf("%s startbit@E+1", name), {31'd0, tx}, 32'd0);
        for (int k = 0; k < n; k++) begin
            for (int b = 0; b < 10; b++) begin
                wait_to(ee + 1 + k * 10 * CPB + b * CPB + CPB / 2);
                f[b] = tx;
            end
            chk($sformatf("%s char%0d", name, k), {22'd0, f}, {22'd0, 1'b1, want[8*k+:8], 1'b0});
        end
        wait_to(ee + 10 * n * CPB);
        chk($sformatf("%s busy before done", name), {31'd0, busy}, 32'd1);
        chk($sformatf("%s done early", name), {31'd0, done}, 32'd0);
        wait_to(ee + 1 + 10 * n * CPB);
        chk($sformatf("%s done", name), {31'd0, done}, 32'd1);
        chk($sformatf("%s busy after", name), {31'd0, busy}, 32'd0);
        chk($sformatf("%s tx idle", name), {31'd0, tx}, 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("reset tx", {31'd0, tx}, 32'd1);
        chk("reset busy", {31'd0, busy}, 32'd0);
        chk("reset done", {31'd0, done}, 32'd0);

        start = 1'b1; yc = 4'd1;
        @(posedge clk);
        #1;
        chk("rst+start busy", {31'd0, busy}, 32'd0);
        chk("rst+start tx", {31'd0, tx}, 32'd1);
        rst = 1'b0; start = 1'b0;
        @(posedge clk);
        #1;
        chk("rst+start no late accept", {31'd0, busy}, 32'd0);

        run_msg(4'd1, 4'd9, 4'd8, 5, {8'h0A, 8'h0D, 8'h38, 8'h39, 8'h31}, "m198");
        @(posedge clk);
        #1;
        chk("m198 done single", {31'd0, done}, 32'd0);

        run_msg(4'd0, 4'd0, 4'd7, 3, {16'h0, 8'h0A, 8'h0D, 8'h37}, "m007");
        @(posedge clk);
        #1;
        run_msg(4'd0, 4'd0, 4'd0, 3, {16'h0, 8'h0A, 8'h0D, 8'h30}, "m000");
        @(posedge clk);
        #1;
        run_msg(4'd0, 4'd5, 4'd0, 4, {8'h0, 8'h0A, 8'h0D, 8'h30, 8'h35}, "m050");
        @(posedge clk);
        #1;
        run_msg(4'd0, 4'hC, 4'd3, 4, {8'h0, 8'h0A, 8'h0D, 8'h33, 8'h3F}, "m0C3");
        @(posedge clk);
        #1;

        t0 = cyc;
        fork
            begin
                wait_to(t0 + 51);
                yc = 4'd9; yd = 4'd9; yu = 4'd9; start = 1'b1;
                @(posedge clk);
                #1;
                start = 1'b0;
            end
        join_none
        run_msg(4'd1, 4'd0, 4'd0, 5, {8'h0A, 8'h0D, 8'h30, 8'h30, 8'h31}, "m100");
        run_msg(4'd0, 4'd0, 4'd7, 3, {16'h0, 8'h0A, 8'h0D, 8'h37}, "b2b007");
        @(posedge clk);
        #1;
        chk("b2b done single", {31'd0, done}, 32'd0);

        yc = 4'd1; yd = 4'd2; yu = 4'd3; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        e = cyc;
        wait_to(e + 59);
        chk("m123 data bit3 before rst", {31'd0, tx}, 32'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("mid rst tx", {31'd0, tx}, 32'd1);
        chk("mid rst busy", {31'd0, busy}, 32'd0);
        chk("mid rst done", {31'd0, done}, 32'd0);
        rst = 1'b0;
        dn = 0;
        repeat (60) begin
            @(posedge clk);
            #1;
            dn += int'(done) + int'(busy);
        end
        chk("after rst quiet", dn, 32'd0);

        run_msg(4'd0, 4'd0, 4'd4, 3, {16'h0, 8'h0A, 8'h0D, 8'h34}, "m004");
        @(posedge clk);
        #1;
        chk("m004 done single", {31'd0, done}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
